// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - shared types, padding constants and helpers for flag_reduce_pipe
package flag_pkg;

   // Fill values for tree inputs beyond WIDTH so they never disturb the result
   localparam logic PAD_OR  = 1'b0;
   localparam logic PAD_AND = 1'b1;
   localparam logic PAD_XOR = 1'b0;

   typedef struct packed {
      logic zero;
      logic ones;
      logic parity;
      logic sign;
   } flags_t;

   // Ceiling log2; returns 0 for n <= 1
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/flag_tree_stage.sv
// rtl/flag_tree_stage.sv - LEVELS levels of OR/AND/XOR reduction followed by a stage register
module flag_tree_stage #(
   parameter  int IN_W   = 32,
   parameter  int LEVELS = 2,
   localparam int OUT_W  = IN_W >> LEVELS
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en_i,
   input  logic             valid_i,
   input  logic             first_i,
   input  logic             last_i,
   input  logic             sign_i,
   input  logic [IN_W-1:0]  or_i,
   input  logic [IN_W-1:0]  and_i,
   input  logic [IN_W-1:0]  xor_i,
   output logic             valid_o,
   output logic             first_o,
   output logic             last_o,
   output logic             sign_o,
   output logic [OUT_W-1:0] or_o,
   output logic [OUT_W-1:0] and_o,
   output logic [OUT_W-1:0] xor_o
);

   logic [OUT_W-1:0] or_d, and_d, xor_d;
   logic [OUT_W-1:0] or_q, and_q, xor_q;
   logic             valid_q, first_q, last_q, sign_q;

   // Each level folds adjacent bit pairs in place; lower indices are rewritten first
   always_comb begin
      logic [IN_W-1:0] or_t, and_t, xor_t;
      or_t  = or_i;
      and_t = and_i;
      xor_t = xor_i;
      for (int lvl = 0; lvl < LEVELS; lvl++) begin
         for (int i = 0; i < (IN_W >> (lvl + 1)); i++) begin
            or_t[i]  = or_t[2*i]  | or_t[2*i+1];
            and_t[i] = and_t[2*i] & and_t[2*i+1];
            xor_t[i] = xor_t[2*i] ^ xor_t[2*i+1];
         end
      end
      or_d  = or_t[OUT_W-1:0];
      and_d = and_t[OUT_W-1:0];
      xor_d = xor_t[OUT_W-1:0];
   end

   // Stage register: partial reductions and sideband move together, only on en_i
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         sign_q  <= 1'b0;
         or_q    <= '0;
         and_q   <= '0;
         xor_q   <= '0;
      end else if (en_i) begin
         valid_q <= valid_i;
         first_q <= first_i;
         last_q  <= last_i;
         sign_q  <= sign_i;
         or_q    <= or_d;
         and_q   <= and_d;
         xor_q   <= xor_d;
      end
   end

   assign valid_o = valid_q;
   assign first_o = first_q;
   assign last_o  = last_q;
   assign sign_o  = sign_q;
   assign or_o    = or_q;
   assign and_o   = and_q;
   assign xor_o   = xor_q;

endmodule

// File: rtl/flag_reduce_pipe.sv
// rtl/flag_reduce_pipe.sv - pipelined zero/ones/parity/sign flag reduction with segment accumulation
module flag_reduce_pipe
   import flag_pkg::*;
#(
   parameter int WIDTH            = 32,
   parameter int LEVELS_PER_STAGE = 2,
   parameter int CNT_W            = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_first,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_zero,
   output logic             out_ones,
   output logic             out_parity,
   output logic             out_sign,
   output logic [CNT_W-1:0] out_words,
   output logic             out_seq_err
);

   localparam int DEPTH  = clog2(WIDTH);
   localparam int STAGES = (DEPTH + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
   localparam int PW     = 1 << DEPTH;

   logic          advance;
   logic [PW-1:0] or_pad, and_pad, xor_pad;

   // Widen the word to a power of two with values neutral for each tree
   for (genvar b = 0; b < PW; b++) begin : g_pad
      if (b < WIDTH) begin : g_data
         assign or_pad[b]  = in_data[b];
         assign and_pad[b] = in_data[b];
         assign xor_pad[b] = in_data[b];
      end else begin : g_fill
         assign or_pad[b]  = PAD_OR;
         assign and_pad[b] = PAD_AND;
         assign xor_pad[b] = PAD_XOR;
      end
   end

   // Tree stages; the last one may cover fewer than LEVELS_PER_STAGE levels
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int IN_W  = PW >> (s * LEVELS_PER_STAGE);
      localparam int REM   = DEPTH - s * LEVELS_PER_STAGE;
      localparam int LV    = (REM < LEVELS_PER_STAGE) ? REM : LEVELS_PER_STAGE;
      localparam int OUT_W = IN_W >> LV;

      logic [IN_W-1:0]  or_in, and_in, xor_in;
      logic             valid_in, first_in, last_in, sign_in;
      logic [OUT_W-1:0] or_out, and_out, xor_out;
      logic             valid_out, first_out, last_out, sign_out;

      if (s == 0) begin : g_head
         assign or_in    = or_pad;
         assign and_in   = and_pad;
         assign xor_in   = xor_pad;
         assign valid_in = in_valid;
         assign first_in = in_first;
         assign last_in  = in_last;
         assign sign_in  = in_data[WIDTH-1];
      end else begin : g_link
         assign or_in    = g_stage[s-1].or_out;
         assign and_in   = g_stage[s-1].and_out;
         assign xor_in   = g_stage[s-1].xor_out;
         assign valid_in = g_stage[s-1].valid_out;
         assign first_in = g_stage[s-1].first_out;
         assign last_in  = g_stage[s-1].last_out;
         assign sign_in  = g_stage[s-1].sign_out;
      end

      flag_tree_stage #(
         .IN_W   (IN_W),
         .LEVELS (LV)
      ) u_stage (
         .clk     (clk),
         .n_rst   (n_rst),
         .en_i    (advance),
         .valid_i (valid_in),
         .first_i (first_in),
         .last_i  (last_in),
         .sign_i  (sign_in),
         .or_i    (or_in),
         .and_i   (and_in),
         .xor_i   (xor_in),
         .valid_o (valid_out),
         .first_o (first_out),
         .last_o  (last_out),
         .sign_o  (sign_out),
         .or_o    (or_out),
         .and_o   (and_out),
         .xor_o   (xor_out)
      );
   end

   logic st_valid, st_first, st_last, st_sign, st_or, st_and, st_xor;

   assign st_valid = g_stage[STAGES-1].valid_out;
   assign st_first = g_stage[STAGES-1].first_out;
   assign st_last  = g_stage[STAGES-1].last_out;
   assign st_sign  = g_stage[STAGES-1].sign_out;
   assign st_or    = g_stage[STAGES-1].or_out[0];
   assign st_and   = g_stage[STAGES-1].and_out[0];
   assign st_xor   = g_stage[STAGES-1].xor_out[0];

   logic             open_q;
   logic             acc_zero_q, acc_ones_q, acc_parity_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             first_eff;
   flags_t           merged;
   logic             out_valid_q;
   flags_t           out_q;
   logic [CNT_W-1:0] out_words_q;
   logic             out_err_q;

   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   // Fold the word leaving the last stage into the open segment (or start a new one)
   always_comb begin
      first_eff   = st_first || !open_q;
      merged.sign = st_sign;
      if (first_eff) begin
         merged.zero   = ~st_or;
         merged.ones   = st_and;
         merged.parity = st_xor;
         cnt_d         = CNT_W'(1);
         // Missing first, or a first that abandons an open segment, both flag the new segment
         err_d         = !st_first || open_q;
      end else begin
         merged.zero   = acc_zero_q & ~st_or;
         merged.ones   = acc_ones_q & st_and;
         merged.parity = acc_parity_q ^ st_xor;
         cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
         err_d         = err_q;
      end
   end

   // Accumulator and output register; frozen while a result waits for out_ready
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         open_q       <= 1'b0;
         acc_zero_q   <= 1'b0;
         acc_ones_q   <= 1'b0;
         acc_parity_q <= 1'b0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         out_words_q  <= '0;
         out_err_q    <= 1'b0;
      end else if (advance) begin
         out_valid_q <= st_valid && st_last;
         if (st_valid) begin
            if (st_last) begin
               out_q       <= merged;
               out_words_q <= cnt_d;
               out_err_q   <= err_d;
               open_q      <= 1'b0;
            end else begin
               acc_zero_q   <= merged.zero;
               acc_ones_q   <= merged.ones;
               acc_parity_q <= merged.parity;
               cnt_q        <= cnt_d;
               err_q        <= err_d;
               open_q       <= 1'b1;
            end
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_zero    = out_q.zero;
   assign out_ones    = out_q.ones;
   assign out_parity  = out_q.parity;
   assign out_sign    = out_q.sign;
   assign out_words   = out_words_q;
   assign out_seq_err = out_err_q;

endmodule
